neuron_mac_sequencer: RTL and testbench
=======================================

Name: neuron_mac_sequencer

Overview:
- Time-multiplexed replacement for one fully unrolled neuron node: a single float_mult and a single float_adder are shared across all N_INPUTS products of one neuron.
- Accepts (activation, weight) FP32 pairs over a valid/ready stream, multiplies each pair, and accumulates the products serially.
- Optionally applies ReLU, then presents the neuron result on a valid/ready output.
- Sits between the layer-level scheduler, which supplies activations and weights from buffers/ROM, and the next layer's input buffer.

Parameters:
- N_INPUTS, 30, number of products per neuron; legal range 1..1024.
- CNT_W, $clog2(N_INPUTS+1), width of the beat counter; derived, do not override.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse that begins a neuron evaluation; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- s_valid  in  1  operand pair valid.
- s_ready  out  1  block can accept an operand pair.
- s_act  in  32  FP32 activation.
- s_wgt  in  32  FP32 weight.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  32  FP32 neuron result.
- beat_cnt  out  CNT_W  number of pairs accepted in the current evaluation.

Behaviour:
- Reset values: state=IDLE, busy=0, s_ready=0, out_valid=0, out_data=32'h0, beat_cnt=0, acc=32'h0, prod_v=0.
- A beat is a cycle with s_valid && s_ready. The product is registered (prod_q = float_mult(s_act, s_wgt), prod_v=1) at the end of the beat cycle.
- Accumulation happens in the cycle after each beat, when prod_v=1:
  - First product of an evaluation: acc <= prod_q, loaded directly with the adder bypassed, so the result does not depend on the adder's zero handling.
  - Later products: acc <= float_adder(acc, prod_q).
- Summation order is strictly sequential in beat order. Results may differ in the last bits from a tree-sum node; this is accepted.
- States and transitions:
  - IDLE: s_ready=0. start=1 -> RUN; beat_cnt is cleared and the first-product flag is set.
  - RUN: s_ready=1. Each beat increments beat_cnt. The beat that makes beat_cnt==N_INPUTS -> DRAIN. s_valid gaps simply stall; there is no timeout.
  - DRAIN: s_ready=0. Lasts exactly 1 cycle, during which the final product is accumulated. Then -> OUT.
  - OUT: out_valid=1, out_data = ReLU(acc), or acc when ReLU is compiled out. out_data is held stable until out_ready=1. The handshake cycle -> IDLE, and out_valid drops on the next cycle.
- Latency: last beat at cycle T -> out_valid high at T+2. Peak throughput is 1 pair per cycle.
- Back-to-back evaluations: start may be asserted in the same cycle as the output handshake; it is ignored because the block is not in IDLE. The earliest restart is the first IDLE cycle.
- start while busy=1 is ignored, with no effect on state or counters.
- s_valid in IDLE, DRAIN or OUT is ignored (s_ready=0), and no beat is counted.
- Reset mid-operation (any state): returns to IDLE with all reset values. The partial sum and any pending product are discarded, and no out_valid pulse is produced.
- ReLU rule: if acc[31]==1 (this includes -0.0 and negative NaN), out_data=32'h0; otherwise out_data=acc.
- N_INPUTS=1: RUN accepts one beat -> DRAIN -> OUT; the result equals that single product.

Optional Feature:
- Macro: NEURON_MAC_RELU_EN.
- Defined: ReLU is applied in OUT as described above.
- Undefined: out_data=acc unmodified, including negative values and -0.0. This is used for the final linear layer.

Decomposition:
- Shared package nn_fp_pkg holds:
  - FP32_W=32, FP32_ZERO=32'h00000000, FP32_ONE=32'h3F800000, FP32_SIGN_BIT=31;
  - state encoding typedef seq_state_t {IDLE, RUN, DRAIN, OUT}.
- Sub-module neuron_mac_datapath:
  - wraps one float_mult and one float_adder together with the prod_q/prod_v/acc registers;
  - inputs: beat, first, and the operands; output: acc;
  - instantiated once by the FSM top.

Test Plan:
- N_INPUTS=4; act=2.0 (32'h40000000) and wgt=1.0 (32'h3F800000) on every cycle, s_valid held high -> out_data=32'h41000000 (8.0); out_valid at T+2; beat_cnt=4.
- Same as above but act=-1.0 (32'hBF800000) -> with NEURON_MAC_RELU_EN out_data=32'h0; without it out_data=32'hC0800000 (-4.0).
- s_valid toggled with 3-cycle gaps between beats; out_ready held low for 5 cycles in OUT -> result is unchanged (8.0), out_data stays stable while waiting, and the block returns to IDLE only after the handshake.
- start pulsed during RUN and again during OUT -> ignored; exactly one result; beat_cnt never exceeds 4.
- rst asserted after 2 beats, then a fresh evaluation of 4 beats of 1.0×1.0 -> no output from the aborted run; the second run gives out_data=32'h40800000 (4.0).
- N_INPUTS=1; act=3.0 (32'h40400000), wgt=-0.5 (32'hBF000000) -> out_data=32'h0 with ReLU, 32'hBFC00000 without.

Source files
------------

// File: rtl/nn_fp_pkg.sv
// rtl/nn_fp_pkg.sv - FP32 constants, sequencer state encoding and ReLU helper
package nn_fp_pkg;

    localparam int          FP32_W        = 32;
    localparam logic [31:0] FP32_ZERO     = 32'h0000_0000;
    localparam logic [31:0] FP32_ONE      = 32'h3F80_0000;
    localparam int          FP32_SIGN_BIT = 31;
    localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        OUT
    } seq_state_t;

    // Any value with the sign bit set (including -0.0 and negative NaN) clamps to +0.0
    function automatic logic [FP32_W-1:0] fp32_relu(input logic [FP32_W-1:0] x);
        return x[FP32_SIGN_BIT] ? FP32_ZERO : x;
    endfunction

endpackage

// File: rtl/float_adder.sv
// rtl/float_adder.sv - combinational FP32 adder, round-to-nearest-even, subnormals flushed to zero
module float_adder
    import nn_fp_pkg::*;
(
    input  logic [FP32_W-1:0] a,
    input  logic [FP32_W-1:0] b,
    output logic [FP32_W-1:0] y
);

    logic        swap, sub, inc;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [31:0] big;
    logic [7:0]  e_sml, e_diff;
    logic [22:0] f_sml, frac;
    logic [26:0] m_big, m_sml, m_aln, m_norm;
    logic [27:0] m_sum;
    logic [24:0] m_rnd;
    logic [4:0]  lz;
    logic [9:0]  e_res;

    // Align the smaller operand with a sticky bit, add/subtract, normalise, round, resolve specials
    always_comb begin
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);

        swap   = (b[30:0] > a[30:0]);
        big    = swap ? b : a;
        e_sml  = swap ? a[30:23] : b[30:23];
        f_sml  = swap ? a[22:0] : b[22:0];
        sub    = a[31] ^ b[31];
        e_diff = big[30:23] - e_sml;

        // Three extra low bits give guard, round and sticky positions
        m_big = {1'b1, big[22:0], 3'b000};
        m_sml = {1'b1, f_sml, 3'b000};
        if (e_diff > 8'd26) begin
            m_aln = 27'h1;
        end else begin
            m_aln = (m_sml >> e_diff) |
                    {26'h0, |(m_sml & ((27'h1 << e_diff) - 27'h1))};
        end

        m_sum = sub ? {1'b0, m_big - m_aln} : ({1'b0, m_big} + {1'b0, m_aln});

        lz = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (m_sum[i]) begin
                lz = 5'(26 - i);
            end
        end

        if (m_sum[27]) begin
            m_norm = {m_sum[27:2], m_sum[1] | m_sum[0]};
            e_res  = {2'b00, big[30:23]} + 10'd1;
        end else begin
            m_norm = m_sum[26:0] << lz;
            e_res  = {2'b00, big[30:23]} - {5'b00000, lz};
        end

        inc   = m_norm[2] & ((|m_norm[1:0]) | m_norm[3]);
        m_rnd = {1'b0, m_norm[26:3]} + {24'h0, inc};
        if (m_rnd[24]) begin
            e_res = e_res + 10'd1;
        end
        frac = m_rnd[24] ? m_rnd[23:1] : m_rnd[22:0];

        if (a_nan || b_nan || (a_inf && b_inf && sub)) begin
            y = FP32_QNAN;
        end else if (a_inf) begin
            y = a;
        end else if (b_inf) begin
            y = b;
        end else if (a_zero && b_zero) begin
            y = {a[31] & b[31], 31'h0};
        end else if (a_zero) begin
            y = b;
        end else if (b_zero) begin
            y = a;
        end else if (m_sum == 28'h0) begin
            y = FP32_ZERO;
        end else if ($signed(e_res) <= 10'sd0) begin
            y = {big[31], 31'h0};
        end else if ($signed(e_res) >= 10'sd255) begin
            y = {big[31], 8'hFF, 23'h0};
        end else begin
            y = {big[31], e_res[7:0], frac};
        end
    end

endmodule

// File: rtl/float_mult.sv
// rtl/float_mult.sv - combinational FP32 multiplier, round-to-nearest-even, subnormals flushed to zero
module float_mult
    import nn_fp_pkg::*;
(
    input  logic [FP32_W-1:0] a,
    input  logic [FP32_W-1:0] b,
    output logic [FP32_W-1:0] y
);

    logic        sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic        g, st, inc;
    logic [47:0] prod;
    logic [23:0] m_top;
    logic [24:0] m_rnd;
    logic [22:0] frac;
    logic [9:0]  e_res;

    // Multiply significands, normalise by at most one place, round, then resolve specials
    always_comb begin
        sgn    = a[31] ^ b[31];
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);

        prod  = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
        e_res = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
        if (prod[47]) begin
            m_top = prod[47:24];
            g     = prod[23];
            st    = |prod[22:0];
            e_res = e_res + 10'd1;
        end else begin
            m_top = prod[46:23];
            g     = prod[22];
            st    = |prod[21:0];
        end
        inc   = g & (st | m_top[0]);
        m_rnd = {1'b0, m_top} + {24'h0, inc};
        if (m_rnd[24]) begin
            e_res = e_res + 10'd1;
        end
        frac = m_rnd[24] ? m_rnd[23:1] : m_rnd[22:0];

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            y = FP32_QNAN;
        end else if (a_inf || b_inf) begin
            y = {sgn, 8'hFF, 23'h0};
        end else if (a_zero || b_zero || ($signed(e_res) <= 10'sd0)) begin
            y = {sgn, 31'h0};
        end else if ($signed(e_res) >= 10'sd255) begin
            y = {sgn, 8'hFF, 23'h0};
        end else begin
            y = {sgn, e_res[7:0], frac};
        end
    end

endmodule

// File: rtl/neuron_mac_datapath.sv
// rtl/neuron_mac_datapath.sv - shared multiplier/adder with product and accumulator registers
module neuron_mac_datapath
    import nn_fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              beat,
    input  logic              first,
    input  logic [FP32_W-1:0] act,
    input  logic [FP32_W-1:0] wgt,
    output logic [FP32_W-1:0] acc
);

    logic [FP32_W-1:0] mult_y, add_y;
    logic [FP32_W-1:0] prod_q, prod_d, acc_q, acc_d;
    logic              prod_v_q, prod_v_d;
    logic              prod_first_q, prod_first_d;

    float_mult u_mult (
        .a (act),
        .b (wgt),
        .y (mult_y)
    );

    float_adder u_add (
        .a (acc_q),
        .b (prod_q),
        .y (add_y)
    );

    // Capture the product on a beat; the following cycle folds it into the accumulator.
    // The first product of an evaluation bypasses the adder so the old sum never leaks in.
    always_comb begin
        prod_v_d     = beat;
        prod_d       = beat ? mult_y : prod_q;
        prod_first_d = beat ? first  : prod_first_q;
        acc_d        = acc_q;
        if (prod_v_q) begin
            acc_d = prod_first_q ? prod_q : add_y;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q       <= FP32_ZERO;
            prod_v_q     <= 1'b0;
            prod_first_q <= 1'b0;
            acc_q        <= FP32_ZERO;
        end else begin
            prod_q       <= prod_d;
            prod_v_q     <= prod_v_d;
            prod_first_q <= prod_first_d;
            acc_q        <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/neuron_mac_sequencer.sv
// rtl/neuron_mac_sequencer.sv - serial MAC neuron sequencer; NEURON_MAC_RELU_EN enables ReLU on the result
module neuron_mac_sequencer
    import nn_fp_pkg::*;
#(
    parameter int N_INPUTS = 30,
    parameter int CNT_W    = $clog2(N_INPUTS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [FP32_W-1:0] s_act,
    input  logic [FP32_W-1:0] s_wgt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP32_W-1:0] out_data,
    output logic [CNT_W-1:0]  beat_cnt
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);

    seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              first_q, first_d;
    logic              beat;
    logic [FP32_W-1:0] acc;

    assign beat = s_valid && s_ready;

    neuron_mac_datapath u_dp (
        .clk   (clk),
        .rst   (rst),
        .beat  (beat),
        .first (first_q),
        .act   (s_act),
        .wgt   (s_wgt),
        .acc   (acc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: DRAIN is a single cycle that lets the last product reach the accumulator
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (beat && (beat_cnt_q == LAST_IDX)) state_d = DRAIN;
            DRAIN:   state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the state; the result is only driven while presented
    always_comb begin
        busy      = (state_q != IDLE);
        s_ready   = (state_q == RUN);
        out_valid = (state_q == OUT);
        out_data  = FP32_ZERO;
        if (state_q == OUT) begin
`ifdef NEURON_MAC_RELU_EN
            out_data = fp32_relu(acc);
`else
            out_data = acc;
`endif
        end
    end

    // Beat counter and first-product flag, both armed by start in IDLE
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        first_d    = first_q;
        if ((state_q == IDLE) && start) begin
            beat_cnt_d = '0;
            first_d    = 1'b1;
        end else if (beat) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            first_d    = 1'b0;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
            first_q    <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            first_q    <= first_d;
        end
    end

    assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// tb/tb_neuron_mac_sequencer.sv - scoreboard bench for neuron_mac_sequencer (N_INPUTS=4 and N_INPUTS=1)
module tb_neuron_mac_sequencer;

    localparam logic [31:0] F_ONE   = 32'h3F80_0000;
    localparam logic [31:0] F_TWO   = 32'h4000_0000;
    localparam logic [31:0] F_MONE  = 32'hBF80_0000;
    localparam logic [31:0] F_THREE = 32'h4040_0000;
    localparam logic [31:0] F_HALF  = 32'h3F00_0000;
    localparam logic [31:0] F_MHALF = 32'hBF00_0000;
    localparam logic [31:0] F_FOUR  = 32'h4080_0000;
    localparam logic [31:0] F_EIGHT = 32'h4100_0000;
    localparam logic [31:0] F_1P5   = 32'h3FC0_0000;
`ifdef NEURON_MAC_RELU_EN
    localparam logic [31:0] EXP_NEG4   = 32'h0000_0000;
    localparam logic [31:0] EXP_NEG1P5 = 32'h0000_0000;
`else
    localparam logic [31:0] EXP_NEG4   = 32'hC080_0000;
    localparam logic [31:0] EXP_NEG1P5 = 32'hBFC0_0000;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start4 = 1'b0, s_valid4 = 1'b0, out_ready4 = 1'b1;
    logic [31:0] s_act4 = '0, s_wgt4 = '0;
    logic        busy4, s_ready4, out_valid4;
    logic [31:0] out_data4;
    logic [2:0]  beat_cnt4;

    logic        start1 = 1'b0, s_valid1 = 1'b0, out_ready1 = 1'b1;
    logic [31:0] s_act1 = '0, s_wgt1 = '0;
    logic        busy1, s_ready1, out_valid1;
    logic [31:0] out_data1;
    logic [0:0]  beat_cnt1;

    neuron_mac_sequencer #(.N_INPUTS(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .start     (start4),
        .busy      (busy4),
        .s_valid   (s_valid4),
        .s_ready   (s_ready4),
        .s_act     (s_act4),
        .s_wgt     (s_wgt4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_data  (out_data4),
        .beat_cnt  (beat_cnt4)
    );

    neuron_mac_sequencer #(.N_INPUTS(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .busy      (busy1),
        .s_valid   (s_valid1),
        .s_ready   (s_ready1),
        .s_act     (s_act1),
        .s_wgt     (s_wgt1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_data  (out_data1),
        .beat_cnt  (beat_cnt1)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] q4[$];
    logic [31:0] q1[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic flag(input string name, input string what);
        n_vec++;
        n_bad++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the 4-input instance: pops the scoreboard on every result handshake
    logic        wait4 = 1'b0;
    logic [31:0] hold4 = '0;
    always @(negedge clk) begin
        if (rst) begin
            wait4 = 1'b0;
        end else if (out_valid4) begin
            if (wait4) chk("hold_stable4", out_data4, hold4);
            if (out_ready4) begin
                if (q4.size() == 0) begin
                    flag("unexpected_out4", $sformatf("result %h with nothing expected", out_data4));
                end else begin
                    chk("result4", out_data4, q4.pop_front());
                    chk("beat_cnt4", 32'(beat_cnt4), 32'd4);
                end
            end
            wait4 = !out_ready4;
            hold4 = out_data4;
        end else begin
            wait4 = 1'b0;
        end
    end

    // Monitor for the 1-input instance
    always @(negedge clk) begin
        if (!rst && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                flag("unexpected_out1", $sformatf("result %h with nothing expected", out_data1));
            end else begin
                chk("result1", out_data1, q1.pop_front());
                chk("beat_cnt1", 32'(beat_cnt1), 32'd1);
            end
        end
    end

    task automatic start_eval4();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
    endtask

    task automatic beat4(input logic [31:0] a, input logic [31:0] w, input bit poke_start);
        int n = 0;
        s_valid4 = 1'b1;
        s_act4   = a;
        s_wgt4   = w;
        start4   = poke_start;
        @(negedge clk);
        while (!s_ready4 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!s_ready4) flag("beat4_timeout", "s_ready stayed 0, required 1");
        tick();
        s_valid4 = 1'b0;
        start4   = 1'b0;
    endtask

    task automatic wait_idle4();
        int n = 0;
        @(negedge clk);
        while (busy4 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (busy4) flag("idle4_timeout", "busy stayed 1, required 0");
        tick();
    endtask

    task automatic wait_out4();
        int n = 0;
        @(negedge clk);
        while (!out_valid4 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!out_valid4) flag("out4_timeout", "out_valid stayed 0, required 1");
    endtask

    task automatic run1(input logic [31:0] a, input logic [31:0] w, input logic [31:0] exp);
        int n = 0;
        q1.push_back(exp);
        start1 = 1'b1;
        tick();
        start1   = 1'b0;
        s_valid1 = 1'b1;
        s_act1   = a;
        s_wgt1   = w;
        @(negedge clk);
        while (!s_ready1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!s_ready1) flag("beat1_timeout", "s_ready stayed 0, required 1");
        tick();
        s_valid1 = 1'b0;
        @(negedge clk);
        chk("lat_drain1", 32'(out_valid1), 32'd0);
        @(negedge clk);
        chk("lat_out1", 32'(out_valid1), 32'd1);
        tick();
        @(negedge clk);
        chk("idle_after1", 32'(busy1), 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_busy4",      32'(busy4),      32'd0);
        chk("rst_s_ready4",   32'(s_ready4),   32'd0);
        chk("rst_out_valid4", 32'(out_valid4), 32'd0);
        chk("rst_out_data4",  out_data4,       32'h0);
        chk("rst_beat_cnt4",  32'(beat_cnt4),  32'd0);
        chk("rst_out_valid1", 32'(out_valid1), 32'd0);
        tick();

        // Four beats of 2.0 x 1.0 back to back; result two cycles after the last beat
        q4.push_back(F_EIGHT);
        start_eval4();
        for (int i = 0; i < 4; i++) beat4(F_TWO, F_ONE, 1'b0);
        @(negedge clk);
        chk("lat_drain4", 32'(out_valid4), 32'd0);
        @(negedge clk);
        chk("lat_out4", 32'(out_valid4), 32'd1);
        wait_idle4();

        // Negative products: ReLU clamps to zero, linear build keeps -4.0
        q4.push_back(EXP_NEG4);
        start_eval4();
        for (int i = 0; i < 4; i++) beat4(F_MONE, F_ONE, 1'b0);
        wait_idle4();

        // Gapped input stream and a stalled consumer
        out_ready4 = 1'b0;
        q4.push_back(F_EIGHT);
        start_eval4();
        for (int i = 0; i < 4; i++) begin
            beat4(F_TWO, F_ONE, 1'b0);
            if (i < 3) repeat (3) tick();
        end
        wait_out4();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_busy4",  32'(busy4),      32'd1);
            chk("stall_valid4", 32'(out_valid4), 32'd1);
        end
        @(posedge clk);
        #1 out_ready4 = 1'b1;
        tick();
        @(negedge clk);
        chk("hs_idle_busy4",  32'(busy4),      32'd0);
        chk("hs_idle_valid4", 32'(out_valid4), 32'd0);
        tick();

        // Start pulses during RUN and on the output handshake cycle are ignored
        out_ready4 = 1'b0;
        q4.push_back(F_EIGHT);
        start_eval4();
        for (int i = 0; i < 4; i++) beat4(F_TWO, F_ONE, i == 1);
        wait_out4();
        @(posedge clk);
        #1;
        start4     = 1'b1;
        out_ready4 = 1'b1;
        tick();
        start4 = 1'b0;
        @(negedge clk);
        chk("hs_start_busy4",    32'(busy4),    32'd0);
        chk("hs_start_s_ready4", 32'(s_ready4), 32'd0);
        tick();

        // Reset after two beats, then a clean run of 1.0 x 1.0
        start_eval4();
        beat4(F_THREE, F_THREE, 1'b0);
        beat4(F_THREE, F_THREE, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy4",      32'(busy4),      32'd0);
        chk("abort_s_ready4",   32'(s_ready4),   32'd0);
        chk("abort_out_valid4", 32'(out_valid4), 32'd0);
        chk("abort_out_data4",  out_data4,       32'h0);
        chk("abort_beat_cnt4",  32'(beat_cnt4),  32'd0);
        repeat (3) tick();
        q4.push_back(F_FOUR);
        start_eval4();
        for (int i = 0; i < 4; i++) beat4(F_ONE, F_ONE, 1'b0);
        wait_idle4();

        // Single-input neuron
        run1(F_THREE, F_MHALF, EXP_NEG1P5);
        run1(F_THREE, F_HALF,  F_1P5);

        repeat (5) tick();
        chk("q4_drained", 32'(q4.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
